// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, fixed-latency valid/ready response.
// Misaligned or out-of-range fetches return a zero word with resp_err set.
module imem_responder #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] START_ADDR = 32'h8000_0000,
  parameter int unsigned      DEPTH_LOG2 = 12,
  parameter int unsigned      LATENCY    = 1,
  parameter string            INIT_FILE  = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_inst,
  output logic             resp_err
);

  localparam int unsigned     Depth     = 1 << DEPTH_LOG2;
  localparam int unsigned     CntW      = (LATENCY > 3) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CntW-1:0] CntLoad   = (LATENCY > 1) ? CntW'(LATENCY - 2) : '0;
  localparam logic [WIDTH:0]  ByteLimit = (WIDTH + 1)'(4) << DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DEPTH_LOG2-1:0] pend_index_q, pend_index_d;
  logic                  pend_err_q, pend_err_d;
  logic [31:0]           inst_q, inst_d;
  logic                  err_q, err_d;
  logic                  take;

  logic [31:0] mem [Depth];

  logic [WIDTH-1:0]      byte_off;
  logic [DEPTH_LOG2-1:0] req_index;
  logic                  req_err;
  logic                  accept;

  // Modular subtract: addresses below START_ADDR wrap far out of range.
  assign byte_off  = req_addr - START_ADDR;
  assign req_index = byte_off[DEPTH_LOG2+1:2];
  assign req_err   = (req_addr[1:0] != 2'b00) | ({1'b0, byte_off} >= ByteLimit);

  assign req_ready  = (state_q == StIdle) | ((state_q == StResp) & resp_ready);
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == StResp);
  assign resp_inst  = inst_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pend_index_d = pend_index_q;
    pend_err_d   = pend_err_q;
    inst_d       = inst_q;
    err_d        = err_q;
    take         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) take = 1'b1;
      end
      StWait: begin
        if (count_q == '0) begin
          state_d = StResp;
          inst_d  = pend_err_q ? 32'h0 : mem[pend_index_q];
          err_d   = pend_err_q;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          if (accept) take = 1'b1;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new accept retires any current response and starts the latency path.
    if (take) begin
      if (LATENCY == 1) begin
        state_d = StResp;
        inst_d  = req_err ? 32'h0 : mem[req_index];
        err_d   = req_err;
      end else begin
        state_d      = StWait;
        count_d      = CntLoad;
        pend_index_d = req_index;
        pend_err_d   = req_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      pend_index_q <= '0;
      pend_err_q   <= 1'b0;
      inst_q       <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pend_index_q <= pend_index_d;
      pend_err_q   <= pend_err_d;
      inst_q       <= inst_d;
      err_q        <= err_d;
    end
  end

endmodule
